// File: rtl/stage_retire_wide_pkg.sv
// Shared types and helpers for the writeback/retire stage.
// ecause_t matches the trap cause encoding used by the CSR block.
package stage_retire_wide_pkg;

  localparam int MAX_LANES = 4;
  localparam int PC_W      = 30;
  localparam int REG_W     = 5;

  typedef enum logic [3:0] {
    IMISALIGN  = 4'd0,
    IFAULT     = 4'd1,
    IILLEGAL   = 4'd2,
    BREAKPOINT = 4'd3,
    LMISALIGN  = 4'd4,
    LFAULT     = 4'd5,
    SMISALIGN  = 4'd6,
    SFAULT     = 4'd7,
    ECALL      = 4'd8
  } ecause_t;

  function automatic logic [2:0] popcount4(input logic [MAX_LANES-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // True when the oldest excepting/flushing lane is a flush rather than an exception.
  function automatic logic surviving_flush(input logic [MAX_LANES-1:0] v,
                                           input logic [MAX_LANES-1:0] e,
                                           input logic [MAX_LANES-1:0] f);
    logic done;
    logic res;
    done = 1'b0;
    res  = 1'b0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (!done && (e[i] || (v[i] && f[i]))) begin
        done = 1'b1;
        res  = ~e[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stage_retire_wide_retire_lane_mask.sv
// In-order kill, retire and register-write mask for one bundle; purely combinational.
// sel is the killing lane when one exists, otherwise the youngest retiring lane.
module retire_lane_mask
  import stage_retire_wide_pkg::*;
#(
  parameter int LANES = 2,
  parameter int SEL_W = 1
) (
  input  logic [LANES-1:0]            valid,
  input  logic [LANES-1:0]            exc,
  input  logic [LANES-1:0]            flush,
  input  logic [LANES-1:0][REG_W-1:0] rd,
  output logic [LANES-1:0]            retire,
  output logic [LANES-1:0]            we,
  output logic [SEL_W-1:0]            sel,
  output logic                        exc_hit,
  output logic                        flush_hit
);

  always_comb begin : p_mask
    logic found;
    retire    = '0;
    we        = '0;
    sel       = '0;
    exc_hit   = 1'b0;
    flush_hit = 1'b0;
    found     = 1'b0;

    // An exception without valid is a fetch-side fault: it still kills younger lanes.
    for (int i = 0; i < LANES; i++) begin
      if (!found) begin
        retire[i] = valid[i] & ~exc[i];
        if (exc[i] || (valid[i] && flush[i])) begin
          found     = 1'b1;
          sel       = SEL_W'(i);
          exc_hit   = exc[i];
          flush_hit = ~exc[i];
        end else if (valid[i]) begin
          sel = SEL_W'(i);
        end
      end
    end

    // Same-rd collisions: the youngest retiring writer wins.
    for (int i = 0; i < LANES; i++) begin
      we[i] = retire[i] & (rd[i] != '0);
      for (int j = i + 1; j < LANES; j++) begin
        if (retire[j] && (rd[j] == rd[i])) we[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/stage_retire_wide.sv
// Writeback/retire stage: registers a LANES-wide bundle, applies in-order kill, drives regfile writes.
// Holds a bundle carrying a surviving flush FLUSH_STALL cycles; effects commit once when the hold ends.
module stage_retire_wide
  import stage_retire_wide_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int XLEN        = 32,
  parameter int FLUSH_STALL = 1,
  parameter int CNT_W       = 64
) (
  input  logic                        clk_core,
  input  logic                        reset,
  input  logic [LANES-1:0]            mem1_valid_wb,
  input  logic [LANES-1:0]            mem1_exc,
  input  ecause_t [LANES-1:0]         mem1_exc_cause,
  input  logic [LANES-1:0]            mem1_flush,
  input  logic [LANES-1:0][PC_W-1:0]  mem1_pc,
  input  logic [LANES-1:0][REG_W-1:0] mem1_wb_reg,
  input  logic [LANES-1:0][XLEN-1:0]  mem1_dout,
  input  logic                        csr_kill,
  output logic                        wb_stall,
  output logic [LANES-1:0]            wb_we,
  output logic [LANES-1:0][REG_W-1:0] wb_reg,
  output logic [LANES-1:0][XLEN-1:0]  wb_data,
  output logic [LANES-1:0]            wb_retire,
  output logic                        wb_exc,
  output ecause_t                     wb_exc_cause,
  output logic                        wb_flush,
  output logic [PC_W-1:0]             wb_pc,
  output logic [CNT_W-1:0]            instret
);

  localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int ST_W  = (FLUSH_STALL > 0) ? $clog2(FLUSH_STALL + 1) : 1;

  typedef struct packed {
    logic              valid;
    logic              exc;
    ecause_t           cause;
    logic              flush;
    logic [PC_W-1:0]   pc;
    logic [REG_W-1:0]  rd;
    logic [XLEN-1:0]   data;
  } retire_lane_t;

  retire_lane_t [LANES-1:0] bund;
  retire_lane_t [LANES-1:0] bund_in;
  logic [ST_W-1:0]          cnt;
  logic                     in_flush;

  logic [LANES-1:0]            b_valid;
  logic [LANES-1:0]            b_exc;
  logic [LANES-1:0]            b_flush;
  logic [LANES-1:0][REG_W-1:0] b_rd;
  logic [LANES-1:0]            m_retire;
  logic [LANES-1:0]            m_we;
  logic [SEL_W-1:0]            m_sel;
  logic                        m_exc_hit;
  logic                        m_flush_hit;

  always_comb begin
    bund_in = '0;
    for (int i = 0; i < LANES; i++) begin
      bund_in[i].valid = mem1_valid_wb[i] & ~csr_kill;
      bund_in[i].exc   = mem1_exc[i] & ~csr_kill;
      bund_in[i].cause = mem1_exc_cause[i];
      bund_in[i].flush = mem1_flush[i] & ~csr_kill;
      bund_in[i].pc    = mem1_pc[i];
      bund_in[i].rd    = mem1_wb_reg[i];
      bund_in[i].data  = mem1_dout[i];
    end
  end

  assign in_flush = surviving_flush(MAX_LANES'(mem1_valid_wb), MAX_LANES'(mem1_exc),
                                    MAX_LANES'(mem1_flush));
  assign wb_stall = (cnt != '0);

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      bund    <= '0;
      cnt     <= '0;
      instret <= '0;
    end else begin
      if (csr_kill)
        cnt <= '0;
      else if (wb_stall)
        cnt <= cnt - 1'b1;
      else if (in_flush && (FLUSH_STALL > 0))
        cnt <= ST_W'(FLUSH_STALL);

      // A kill while holding drops the held bundle without it ever retiring.
      if (!wb_stall)
        bund <= bund_in;
      else if (csr_kill)
        bund <= '0;

      if (!wb_stall)
        instret <= instret + CNT_W'(popcount4(MAX_LANES'(wb_retire)));
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      b_valid[i] = bund[i].valid;
      b_exc[i]   = bund[i].exc;
      b_flush[i] = bund[i].flush;
      b_rd[i]    = bund[i].rd;
      wb_reg[i]  = bund[i].rd;
      wb_data[i] = bund[i].data;
    end
  end

  retire_lane_mask #(
    .LANES (LANES),
    .SEL_W (SEL_W)
  ) u_mask (
    .valid     (b_valid),
    .exc       (b_exc),
    .flush     (b_flush),
    .rd        (b_rd),
    .retire    (m_retire),
    .we        (m_we),
    .sel       (m_sel),
    .exc_hit   (m_exc_hit),
    .flush_hit (m_flush_hit)
  );

  assign wb_retire    = m_retire & {LANES{~wb_stall}};
  assign wb_we        = m_we & {LANES{~wb_stall}};
  assign wb_exc       = m_exc_hit;
  assign wb_flush     = m_flush_hit;
  assign wb_exc_cause = m_exc_hit ? bund[m_sel].cause : IMISALIGN;
  assign wb_pc        = bund[m_sel].pc;

endmodule

// File: tb/tb_stage_retire_wide.sv
// Directed bench for stage_retire_wide: two lanes, FLUSH_STALL=2, plus a 2-bit instret copy for wrap.
module tb_stage_retire_wide;
  import stage_retire_wide_pkg::*;

  logic                 clk_core = 1'b0;
  logic                 reset;
  logic [1:0]           in_valid;
  logic [1:0]           in_exc;
  ecause_t [1:0]        in_cause;
  logic [1:0]           in_flush;
  logic [1:0][29:0]     in_pc;
  logic [1:0][4:0]      in_rd;
  logic [1:0][31:0]     in_dout;
  logic                 csr_kill;

  logic                 wb_stall, wb_exc, wb_flush;
  logic [1:0]           wb_we, wb_retire;
  logic [1:0][4:0]      wb_reg;
  logic [1:0][31:0]     wb_data;
  ecause_t              wb_exc_cause;
  logic [29:0]          wb_pc;
  logic [63:0]          instret;

  logic                 w_stall, w_exc, w_flush;
  logic [1:0]           w_we, w_retire;
  logic [1:0][4:0]      w_reg;
  logic [1:0][31:0]     w_data;
  ecause_t              w_exc_cause;
  logic [29:0]          w_pc;
  logic [1:0]           w_instret;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_ins;

  always #5 clk_core = ~clk_core;

  stage_retire_wide #(.LANES(2), .XLEN(32), .FLUSH_STALL(2), .CNT_W(64)) u_dut (
    .clk_core(clk_core), .reset(reset), .mem1_valid_wb(in_valid), .mem1_exc(in_exc),
    .mem1_exc_cause(in_cause), .mem1_flush(in_flush), .mem1_pc(in_pc), .mem1_wb_reg(in_rd),
    .mem1_dout(in_dout), .csr_kill(csr_kill), .wb_stall(wb_stall), .wb_we(wb_we),
    .wb_reg(wb_reg), .wb_data(wb_data), .wb_retire(wb_retire), .wb_exc(wb_exc),
    .wb_exc_cause(wb_exc_cause), .wb_flush(wb_flush), .wb_pc(wb_pc), .instret(instret)
  );

  stage_retire_wide #(.LANES(2), .XLEN(32), .FLUSH_STALL(2), .CNT_W(2)) u_wrap (
    .clk_core(clk_core), .reset(reset), .mem1_valid_wb(in_valid), .mem1_exc(in_exc),
    .mem1_exc_cause(in_cause), .mem1_flush(in_flush), .mem1_pc(in_pc), .mem1_wb_reg(in_rd),
    .mem1_dout(in_dout), .csr_kill(csr_kill), .wb_stall(w_stall), .wb_we(w_we),
    .wb_reg(w_reg), .wb_data(w_data), .wb_retire(w_retire), .wb_exc(w_exc),
    .wb_exc_cause(w_exc_cause), .wb_flush(w_flush), .wb_pc(w_pc), .instret(w_instret)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic clear_in();
    in_valid = '0;
    in_exc   = '0;
    in_flush = '0;
    in_pc    = '0;
    in_rd    = '0;
    in_dout  = '0;
    for (int i = 0; i < 2; i++) in_cause[i] = IMISALIGN;
  endtask

  task automatic set_lane(input int i, input logic v, input logic e, input ecause_t c,
                          input logic f, input logic [29:0] pc, input logic [4:0] rd,
                          input logic [31:0] d);
    in_valid[i] = v;
    in_exc[i]   = e;
    in_cause[i] = c;
    in_flush[i] = f;
    in_pc[i]    = pc;
    in_rd[i]    = rd;
    in_dout[i]  = d;
  endtask

  initial begin
    reset    = 1'b1;
    csr_kill = 1'b0;
    clear_in();
    #12;
    check("rst_stall",   64'(wb_stall), 64'd0);
    check("rst_we",      64'(wb_we), 64'd0);
    check("rst_retire",  64'(wb_retire), 64'd0);
    check("rst_exc",     64'({wb_exc, wb_flush}), 64'd0);
    check("rst_instret", instret, 64'd0);
    @(negedge clk_core);
    reset = 1'b0;
    exp_ins = 64'd0;

    // Two independent writes.
    set_lane(0, 1'b1, 1'b0, IMISALIGN, 1'b0, 30'h10, 5'd3, 32'h11);
    set_lane(1, 1'b1, 1'b0, IMISALIGN, 1'b0, 30'h11, 5'd5, 32'h22);
    step();
    check("t1_we",     64'(wb_we), 64'b11);
    check("t1_retire", 64'(wb_retire), 64'b11);
    check("t1_data0",  64'(wb_data[0]), 64'h11);
    check("t1_data1",  64'(wb_data[1]), 64'h22);
    check("t1_reg1",   64'(wb_reg[1]), 64'd5);
    check("t1_pc",     64'(wb_pc), 64'h11);
    check("t1_ins_pre", instret, exp_ins);
    clear_in();
    step();
    exp_ins = exp_ins + 2;
    check("t1_instret", instret, exp_ins);

    // Oldest lane excepts: nothing retires.
    set_lane(0, 1'b1, 1'b1, IILLEGAL, 1'b0, 30'h40, 5'd2, 32'h33);
    set_lane(1, 1'b1, 1'b0, IMISALIGN, 1'b0, 30'h41, 5'd4, 32'h44);
    step();
    check("t2_exc",    64'(wb_exc), 64'd1);
    check("t2_cause",  64'(wb_exc_cause), 64'(IILLEGAL));
    check("t2_pc",     64'(wb_pc), 64'h40);
    check("t2_retire", 64'(wb_retire), 64'd0);
    check("t2_we",     64'(wb_we), 64'd0);
    check("t2_flush",  64'(wb_flush), 64'd0);
    clear_in();
    step();
    check("t2_instret", instret, exp_ins);

    // Flush in lane 0 holds two cycles then retires lane 0 only.
    set_lane(0, 1'b1, 1'b0, IMISALIGN, 1'b1, 30'h20, 5'd4, 32'h55);
    set_lane(1, 1'b1, 1'b0, IMISALIGN, 1'b0, 30'h21, 5'd6, 32'h66);
    step();
    clear_in();
    check("t3_stall1",  64'(wb_stall), 64'd1);
    check("t3_ret1",    64'(wb_retire), 64'd0);
    check("t3_flush",   64'(wb_flush), 64'd1);
    step();
    check("t3_stall2",  64'(wb_stall), 64'd1);
    check("t3_we2",     64'(wb_we), 64'd0);
    step();
    check("t3_stall3",  64'(wb_stall), 64'd0);
    check("t3_retire",  64'(wb_retire), 64'b01);
    check("t3_we",      64'(wb_we), 64'b01);
    check("t3_pc",      64'(wb_pc), 64'h20);
    step();
    exp_ins = exp_ins + 1;
    check("t3_ret_after", 64'(wb_retire), 64'd0);
    check("t3_instret",   instret, exp_ins);

    // Same rd in both lanes: youngest write wins; also takes the 2-bit counter through wrap.
    set_lane(0, 1'b1, 1'b0, IMISALIGN, 1'b0, 30'h30, 5'd7, 32'hA);
    set_lane(1, 1'b1, 1'b0, IMISALIGN, 1'b0, 30'h31, 5'd7, 32'hB);
    step();
    check("t4_we",     64'(wb_we), 64'b10);
    check("t4_retire", 64'(wb_retire), 64'b11);
    check("t4_data1",  64'(wb_data[1]), 64'hB);
    clear_in();
    set_lane(0, 1'b1, 1'b0, IMISALIGN, 1'b0, 30'h32, 5'd0, 32'hC);
    step();
    exp_ins = exp_ins + 2;
    check("t4_instret", instret, exp_ins);
    check("t4_wrap",    64'(w_instret), 64'd1);
    check("t4_rd0_we",  64'(wb_we), 64'd0);
    check("t4_rd0_ret", 64'(wb_retire), 64'b01);
    clear_in();
    step();
    exp_ins = exp_ins + 1;
    check("t4_instret2", instret, exp_ins);
    check("t4_wrap2",    64'(w_instret), exp_ins & 64'd3);

    // csr_kill while holding drops the bundle.
    set_lane(0, 1'b1, 1'b0, IMISALIGN, 1'b1, 30'h50, 5'd8, 32'h77);
    set_lane(1, 1'b1, 1'b0, IMISALIGN, 1'b0, 30'h51, 5'd9, 32'h88);
    step();
    clear_in();
    check("t5_stall",  64'(wb_stall), 64'd1);
    csr_kill = 1'b1;
    step();
    csr_kill = 1'b0;
    check("t5_stall_drop", 64'(wb_stall), 64'd0);
    check("t5_retire",     64'(wb_retire), 64'd0);
    check("t5_flush",      64'(wb_flush), 64'd0);
    step();
    check("t5_instret", instret, exp_ins);

    // Fetch fault without valid still reports an exception.
    set_lane(0, 1'b0, 1'b1, IFAULT, 1'b0, 30'h60, 5'd1, 32'h0);
    set_lane(1, 1'b1, 1'b0, IMISALIGN, 1'b0, 30'h61, 5'd2, 32'h1);
    step();
    check("t6_exc",    64'(wb_exc), 64'd1);
    check("t6_cause",  64'(wb_exc_cause), 64'(IFAULT));
    check("t6_retire", 64'(wb_retire), 64'd0);
    clear_in();
    step();
    check("t6_instret", instret, exp_ins);

    // Asynchronous reset in the middle of a hold.
    set_lane(0, 1'b1, 1'b0, IMISALIGN, 1'b1, 30'h70, 5'd3, 32'h99);
    step();
    clear_in();
    check("t7_stall", 64'(wb_stall), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t7_rst_stall",   64'(wb_stall), 64'd0);
    check("t7_rst_flush",   64'(wb_flush), 64'd0);
    check("t7_rst_retire",  64'(wb_retire), 64'd0);
    check("t7_rst_pc",      64'(wb_pc), 64'd0);
    check("t7_rst_instret", instret, 64'd0);
    check("t7_rst_wrap",    64'(w_instret), 64'd0);
    @(negedge clk_core);
    reset = 1'b0;
    step();
    check("t7_post_retire", 64'(wb_retire), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
